// File: rtl/bus_rr_arbiter_if.sv
// Shared bus between NUM_MASTERS masters and NUM_SLAVES slaves.
// master modport: the environment side (masters drive requests, slaves drive read data).
// slave modport : the arbiter/fabric side (drives grants, decoded slave controls, read return).
// Signals: m_req/m_wr/m_addr/m_dout per master (packed, master k at [k*W +: W]),
//          s_dout per slave (packed), m_grant one-hot, m_din read broadcast,
//          m_err unmapped pulse, s_sel/s_addr/s_wr/s_din slave-side access.
interface bus_rr_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 2,
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 64
);
    logic [NUM_MASTERS-1:0]    m_req;
    logic [NUM_MASTERS-1:0]    m_wr;
    logic [NUM_MASTERS*AW-1:0] m_addr;
    logic [NUM_MASTERS*DW-1:0] m_dout;
    logic [NUM_SLAVES*DW-1:0]  s_dout;
    logic [NUM_MASTERS-1:0]    m_grant;
    logic [DW-1:0]             m_din;
    logic                      m_err;
    logic [NUM_SLAVES-1:0]     s_sel;
    logic [AW-1:0]             s_addr;
    logic                      s_wr;
    logic [DW-1:0]             s_din;

    modport master (
        output m_req, m_wr, m_addr, m_dout, s_dout,
        input  m_grant, m_din, m_err, s_sel, s_addr, s_wr, s_din
    );

    modport slave (
        input  m_req, m_wr, m_addr, m_dout, s_dout,
        output m_grant, m_din, m_err, s_sel, s_addr, s_wr, s_din
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbitrated shared bus: NUM_MASTERS masters onto NUM_SLAVES slaves.
// Ports: clk, reset (synchronous, active-high), bus (slave modport of bus_rr_arbiter_if).
// Grant and m_err are registered; slave-side controls are combinational from the owner;
// read data returns through a registered slave index so it aligns with sync-read memories.
module bus_rr_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 2,
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 64,
    parameter int unsigned SPAN_BITS   = 5,
    parameter int unsigned MAX_HOLD    = 0
) (
    input  logic            clk,
    input  logic            reset,
    bus_rr_arbiter_if.slave bus
);
    localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned IW = AW - SPAN_BITS;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [MW-1:0]          r_owner, w_owner_nxt;
    logic [MW-1:0]          r_last, w_last_nxt;
    logic [HW-1:0]          r_hold, w_hold_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic                   r_rd_vld;
    logic [SW-1:0]          r_rd_idx;
    logic                   r_err;

    logic                   w_owned;
    logic                   w_acc;
    logic                   w_mapped;
    logic                   w_wr_req;
    logic                   w_force;
    logic                   w_hold_sat;
    logic [MW:0]            w_pick;
    logic [IW-1:0]          w_idx;
    logic [AW-1:0]          w_addr;
    logic [DW-1:0]          w_wdata;
    logic [NUM_SLAVES-1:0]  w_sel;

    // First requester after 'base' (wrapping), looking at most 'span' positions ahead.
    // Returns {found, index}.
    function automatic logic [MW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [MW-1:0]          base,
                                            input int unsigned            span);
        logic [MW:0] res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            j = (32'(base) + i) % NUM_MASTERS;
            if (!res[MW] && (i <= span) && req[MW'(j)]) begin
                res = {1'b1, MW'(j)};
            end
        end
        return res;
    endfunction

    // Owner mux and address decode
    always_comb begin
        w_owned  = (r_state == ST_OWNED);
        w_addr   = '0;
        w_wdata  = '0;
        w_wr_req = 1'b0;
        w_acc    = 1'b0;
        if (w_owned) begin
            w_addr   = bus.m_addr[32'(r_owner)*AW +: AW];
            w_wdata  = bus.m_dout[32'(r_owner)*DW +: DW];
            w_wr_req = bus.m_wr[r_owner];
            w_acc    = bus.m_req[r_owner];
        end
        w_idx    = w_addr[AW-1:SPAN_BITS];
        w_mapped = w_acc && (32'(w_idx) < NUM_SLAVES);
    end

    // One-hot slave select, only for a live mapped access
    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            w_sel[i] = w_mapped && (32'(w_idx) == i);
        end
    end

    // Arbiter next state: hold, release/handover, forced handover
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        w_pick      = '0;
        w_force     = (MAX_HOLD > 0) && (32'(r_hold) == MAX_HOLD - 1);
        w_hold_sat  = (MAX_HOLD == 0) || (32'(r_hold) >= MAX_HOLD - 1);

        case (r_state)
            ST_IDLE: begin
                w_pick = rr_pick(bus.m_req, r_last, NUM_MASTERS);
                if (w_pick[MW]) begin
                    w_state_nxt = ST_OWNED;
                    w_owner_nxt = w_pick[MW-1:0];
                    w_hold_nxt  = '0;
                end
            end
            ST_OWNED: begin
                // Candidates exclude the current owner in both release and forced cases.
                w_pick = rr_pick(bus.m_req, r_owner, NUM_MASTERS - 1);
                if (!bus.m_req[r_owner]) begin
                    w_last_nxt = r_owner;
                    w_hold_nxt = '0;
                    if (w_pick[MW]) begin
                        w_owner_nxt = w_pick[MW-1:0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_force && w_pick[MW]) begin
                    w_last_nxt  = r_owner;
                    w_owner_nxt = w_pick[MW-1:0];
                    w_hold_nxt  = '0;
                end else if (!w_hold_sat) begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_grant_nxt = '0;
        if (w_state_nxt == ST_OWNED) begin
            w_grant_nxt[w_owner_nxt] = 1'b1;
        end
    end

    // State, grant, read-return and error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_last   <= MW'(NUM_MASTERS - 1);
            r_hold   <= '0;
            r_grant  <= '0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_last   <= w_last_nxt;
            r_hold   <= w_hold_nxt;
            r_grant  <= w_grant_nxt;
            r_rd_vld <= w_mapped && !w_wr_req;
            r_rd_idx <= SW'(w_idx);
            r_err    <= w_acc && !w_mapped;
        end
    end

    assign bus.m_grant = r_grant;
    assign bus.m_err   = r_err;
    assign bus.s_sel   = w_sel;
    assign bus.s_addr  = w_addr;
    assign bus.s_din   = w_wdata;
    assign bus.s_wr    = w_mapped && w_wr_req;
    assign bus.m_din   = r_rd_vld ? bus.s_dout[32'(r_rd_idx)*DW +: DW] : '0;
endmodule
